controlador_saida_display: RTL and testbench
============================================

# controlador_saida_display

Sequential output-display stage fed directly by the output multiplexer's selected value (`escolhido_multiplexador_saida`). On each OUT instruction it captures the value, converts it to BCD with a shift-and-add-3 (double-dabble) engine, and drives the board's active-low 7-segment displays. It applies leading-zero blanking and overflow indication. A one-deep pending buffer absorbs OUT instructions that arrive while a conversion is in progress.

## Interface
- `DATA_WIDTH`, 32, width of the captured value, treated as unsigned.
- `NUM_DIGITOS`, 8, number of physical 7-segment displays.
- Local `NUM_DIG_INT` = (DATA_WIDTH*3)/10 + 1, internal BCD digit count (10 for 32 bits).

Ports:
- `clock`  in  1  single clock for the whole block.
- `reset_n`  in  1  asynchronous, active-low reset.
- `out`  in  1  OUT control; sampled every rising edge; high means capture `dado_saida`.
- `dado_saida`  in  DATA_WIDTH  value from the output multiplexer.
- `ocupado`  out  1  conversion in progress or pending.
- `pronto`  out  1  one-cycle pulse when the displays update.
- `overflow`  out  1  last displayed value needed more than NUM_DIGITOS digits.
- `bcd_digitos`  out  4*NUM_DIGITOS  registered BCD of the last result; digit 0 is in the LSBs.
- `segmentos`  out  7*NUM_DIGITOS  registered, active-low, per-digit bit order {g,f,e,d,c,b,a}; digit 0 is in the LSBs.

## Operation
- FSM states: OCIOSO, CONVERTE, ATUALIZA.
- **OCIOSO** with `out`=1:
  - Load shift register {BCD=0, bin=`dado_saida`} and set counter = DATA_WIDTH.
  - Go to CONVERTE.
- **CONVERTE**, one iteration per edge:
  - Add 3 to each BCD nibble ≥5, then shift the whole register left by 1.
  - Decrement the counter.
  - After the iteration that takes the counter to 0, go to ATUALIZA.
- **ATUALIZA**, single cycle:
  - Register `bcd_digitos` (low NUM_DIGITOS digits).
  - Register `overflow` = any internal digit above NUM_DIGITOS is nonzero.
  - Register `segmentos`.
  - Pulse `pronto`.
  - If pending is valid, load the pending value, clear pending and go to CONVERTE. Otherwise go to OCIOSO.
- **Pending buffer**:
  - `out`=1 in CONVERTE or ATUALIZA writes `dado_saida` into pending and sets it valid.
  - A newer write overwrites an older one, so only the latest is kept.
  - If `out` is high in ATUALIZA while pending is already valid, the new value wins and is the one loaded.
- **Segment encoding**:
  - Digits 0-9: standard patterns (0=1000000, 1=1111001, 4=0011001, 9=0010000).
  - Blank = 1111111; dash = 0111111.
- **Blanking**: digits above the most significant nonzero digit are blank. Digit 0 always shows its value, so 0 displays as "0".
- **Overflow**: all NUM_DIGITOS displays show dash. `bcd_digitos` still holds the low digits.
- `ocupado` = (state != OCIOSO) or pending valid.

## Timing
- **Reset** (async assert; deassert synchronized externally):
  - State OCIOSO, pending cleared.
  - `ocupado`=0, `pronto`=0, `overflow`=0.
  - `bcd_digitos`=0, `segmentos` all blank (all ones).
- **Latency**: `out` sampled at edge E0.
  - `ocupado`=1 after E0.
  - Iterations occur at E1..E_DATA_WIDTH.
  - Outputs update and `pronto`=1 after E(DATA_WIDTH+1), i.e. E33 for the default width.
  - `pronto` lasts exactly one cycle.
- **Back-to-back**: no idle cycle between ATUALIZA and the next CONVERTE. `ocupado` stays 1 throughout.
- Displays hold their value indefinitely between updates.
- Reset mid-conversion aborts with no `pronto` and no display change beyond the reset values.

## Structure
- Shared package/header `display_defs`:
  - FSM state encoding.
  - Segment constants: SEG_BLANK, SEG_DASH, digit table.
- Natural sub-module: `decodificador_7seg`, combinational 4-bit BCD → 7-bit active-low segments, instantiated NUM_DIGITOS times.
- Blanking and overflow muxing stay in the top block.

## Test plan
- Reset, then `out` pulse with 1234 → `pronto` after E33, `bcd_digitos`=0x00001234, `overflow`=0. Digit0=0011001 ('4'), digit3=1111001 ('1'), digits 4-7 blank.
- `out` with 0 → digit0=1000000, digits 1-7=1111111, `bcd_digitos`=0.
- `out` with 99999999 → all digits 0010000, `overflow`=0. Then 100000000 and 0xFFFFFFFF → `overflow`=1, all digits 0111111.
- `out`=5 at cycle 0, `out`=7 at cycle 10, `out`=42 at cycle 20 → first `pronto` shows 5. Second conversion starts immediately and shows 42 at the second `pronto`; 7 is never displayed. `ocupado`=1 continuously for 66 cycles.
- `out` asserted in the ATUALIZA cycle with value 3 → 3 becomes pending and is displayed one full conversion later.
- `reset_n` low at cycle 15 of a conversion of 777 → all outputs return to reset values immediately, no `pronto`, pending cleared. A subsequent `out`=8 converts normally.

Source files
------------

// File: rtl/display_defs.sv
// Shared definitions for the output-display stage: FSM states and the
// active-low 7-segment patterns in {g,f,e,d,c,b,a} order.
package display_defs;

    typedef enum logic [1:0] {
        OCIOSO,
        CONVERTE,
        ATUALIZA
    } estado_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    // Codes 10-15 never appear in valid BCD; they are shown blank.
    function automatic logic [6:0] seg_digito(input logic [3:0] digito);
        logic [6:0] seg;
        seg = SEG_BLANK;
        case (digito)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/decodificador_7seg.sv
// Combinational BCD digit to active-low 7-segment pattern.
module decodificador_7seg
    import display_defs::*;
(
    input  logic [3:0] digito_i,
    output logic [6:0] segmentos_o
);

    always_comb begin
        segmentos_o = seg_digito(digito_i);
    end

endmodule

// File: rtl/controlador_saida_display.sv
// Captures the output-mux value on OUT, converts it to BCD by double-dabble
// and drives blanked / overflow-aware active-low 7-segment displays.
module controlador_saida_display
    import display_defs::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned NUM_DIGITOS = 8
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     out,
    input  logic [DATA_WIDTH-1:0]    dado_saida,
    output logic                     ocupado,
    output logic                     pronto,
    output logic                     overflow,
    output logic [4*NUM_DIGITOS-1:0] bcd_digitos,
    output logic [7*NUM_DIGITOS-1:0] segmentos
);

    localparam int unsigned NUM_DIG_INT = (DATA_WIDTH * 3) / 10 + 1;
    localparam int unsigned BCD_W       = 4 * NUM_DIG_INT;
    localparam int unsigned SR_W        = BCD_W + DATA_WIDTH;
    localparam int unsigned CW          = $clog2(DATA_WIDTH + 1);

    estado_t                    estado_q, estado_d;
    logic [SR_W-1:0]            sr_q, sr_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]      pend_q, pend_d;
    logic                       pend_v_q, pend_v_d;
    logic                       pronto_q, pronto_d;
    logic                       ovf_q, ovf_d;
    logic [4*NUM_DIGITOS-1:0]   bcd_q, bcd_d;
    logic [7*NUM_DIGITOS-1:0]   seg_q, seg_d;

    logic [BCD_W-1:0]           bcd_int;
    logic                       ovf_int;
    logic [7*NUM_DIGITOS-1:0]   seg_dec;
    logic [7*NUM_DIGITOS-1:0]   seg_fmt;

    function automatic logic [SR_W-1:0] passo_dabble(input logic [SR_W-1:0] sr);
        logic [SR_W-1:0] t;
        t = sr;
        for (int unsigned i = 0; i < NUM_DIG_INT; i++) begin
            if (t[DATA_WIDTH + 4*i +: 4] >= 4'd5) begin
                t[DATA_WIDTH + 4*i +: 4] = t[DATA_WIDTH + 4*i +: 4] + 4'd3;
            end
        end
        return {t[SR_W-2:0], 1'b0};
    endfunction

    assign bcd_int = sr_q[SR_W-1 -: BCD_W];

    generate
        if (NUM_DIG_INT > NUM_DIGITOS) begin : g_ovf
            assign ovf_int = |bcd_int[BCD_W-1:4*NUM_DIGITOS];
        end else begin : g_sem_ovf
            assign ovf_int = 1'b0;
        end
    endgenerate

    for (genvar g = 0; g < NUM_DIGITOS; g++) begin : g_dec
        decodificador_7seg u_dec (
            .digito_i    (bcd_int[4*g +: 4]),
            .segmentos_o (seg_dec[7*g +: 7])
        );
    end

    // Scan from the top digit down; a digit becomes visible once any digit at
    // or above it is nonzero, and digit 0 is always visible.
    always_comb begin
        logic        visivel;
        int unsigned idx;
        visivel = 1'b0;
        idx     = 0;
        seg_fmt = '1;
        for (int unsigned k = 0; k < NUM_DIGITOS; k++) begin
            idx     = NUM_DIGITOS - 1 - k;
            visivel = visivel | (bcd_int[4*idx +: 4] != 4'd0) | (idx == 0);
            if (ovf_int) begin
                seg_fmt[7*idx +: 7] = SEG_DASH;
            end else if (visivel) begin
                seg_fmt[7*idx +: 7] = seg_dec[7*idx +: 7];
            end else begin
                seg_fmt[7*idx +: 7] = SEG_BLANK;
            end
        end
    end

    always_comb begin
        estado_d = estado_q;
        sr_d     = sr_q;
        cnt_d    = cnt_q;
        pend_d   = pend_q;
        pend_v_d = pend_v_q;
        pronto_d = 1'b0;
        ovf_d    = ovf_q;
        bcd_d    = bcd_q;
        seg_d    = seg_q;

        if (out && (estado_q != OCIOSO)) begin
            pend_d   = dado_saida;
            pend_v_d = 1'b1;
        end

        case (estado_q)
            OCIOSO: begin
                if (out) begin
                    sr_d     = {{BCD_W{1'b0}}, dado_saida};
                    cnt_d    = CW'(DATA_WIDTH);
                    estado_d = CONVERTE;
                end
            end
            CONVERTE: begin
                sr_d  = passo_dabble(sr_q);
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    estado_d = ATUALIZA;
                end
            end
            ATUALIZA: begin
                bcd_d    = bcd_int[4*NUM_DIGITOS-1:0];
                ovf_d    = ovf_int;
                seg_d    = seg_fmt;
                pronto_d = 1'b1;
                // A write in this very cycle supersedes any older pending value,
                // so it is loaded straight away instead of via the buffer.
                if (out) begin
                    sr_d     = {{BCD_W{1'b0}}, dado_saida};
                    cnt_d    = CW'(DATA_WIDTH);
                    pend_v_d = 1'b0;
                    estado_d = CONVERTE;
                end else if (pend_v_q) begin
                    sr_d     = {{BCD_W{1'b0}}, pend_q};
                    cnt_d    = CW'(DATA_WIDTH);
                    pend_v_d = 1'b0;
                    estado_d = CONVERTE;
                end else begin
                    estado_d = OCIOSO;
                end
            end
            default: begin
                estado_d = OCIOSO;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado_q <= OCIOSO;
            sr_q     <= '0;
            cnt_q    <= '0;
            pend_q   <= '0;
            pend_v_q <= 1'b0;
            pronto_q <= 1'b0;
            ovf_q    <= 1'b0;
            bcd_q    <= '0;
            seg_q    <= '1;
        end else begin
            estado_q <= estado_d;
            sr_q     <= sr_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
            pronto_q <= pronto_d;
            ovf_q    <= ovf_d;
            bcd_q    <= bcd_d;
            seg_q    <= seg_d;
        end
    end

    assign ocupado     = (estado_q != OCIOSO) || pend_v_q;
    assign pronto      = pronto_q;
    assign overflow    = ovf_q;
    assign bcd_digitos = bcd_q;
    assign segmentos   = seg_q;

endmodule

// File: tb/tb_controlador_saida_display.sv
// Directed bench for controlador_saida_display with hand-computed expectations.
module tb_controlador_saida_display;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] BL = 7'b1111111;
    localparam logic [6:0] DS = 7'b0111111;

    logic        clock;
    logic        reset_n;
    logic        out;
    logic [31:0] dado_saida;
    logic        ocupado;
    logic        pronto;
    logic        overflow;
    logic [31:0] bcd_digitos;
    logic [55:0] segmentos;

    int n_cmp;
    int n_err;

    controlador_saida_display #(
        .DATA_WIDTH  (32),
        .NUM_DIGITOS (8)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .out         (out),
        .dado_saida  (dado_saida),
        .ocupado     (ocupado),
        .pronto      (pronto),
        .overflow    (overflow),
        .bcd_digitos (bcd_digitos),
        .segmentos   (segmentos)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp_v);
        end
    endtask

    // Pulse out for one edge, then count cycles until pronto (bounded).
    task automatic conv(input logic [31:0] v, output int lat, output logic ocu0);
        out        = 1'b1;
        dado_saida = v;
        @(negedge clock);
        out  = 1'b0;
        lat  = 0;
        ocu0 = ocupado;
        while (!pronto && lat < 60) begin
            @(negedge clock);
            lat++;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic        ocu0;
        int          p_cnt, p1, p2, ocup1, npr;
        logic        ocup_after;
        logic [31:0] b1, b2;
        logic [55:0] s2;

        n_cmp      = 0;
        n_err      = 0;
        out        = 1'b0;
        dado_saida = '0;
        reset_n    = 1'b0;
        repeat (3) @(negedge clock);

        chk("rst_ocupado",  {63'd0, ocupado},  64'd0);
        chk("rst_pronto",   {63'd0, pronto},   64'd0);
        chk("rst_overflow", {63'd0, overflow}, 64'd0);
        chk("rst_bcd",      {32'd0, bcd_digitos}, 64'd0);
        chk("rst_seg",      {8'd0, segmentos}, {8'd0, {8{BL}}});
        reset_n = 1'b1;
        @(negedge clock);

        conv(32'd1234, lat, ocu0);
        chk("1234_ocupado", {63'd0, ocu0}, 64'd1);
        chk("1234_latency", 64'(lat), 64'd33);
        chk("1234_bcd", {32'd0, bcd_digitos}, 64'h0000_1234);
        chk("1234_ovf", {63'd0, overflow}, 64'd0);
        chk("1234_seg", {8'd0, segmentos}, {8'd0, BL, BL, BL, BL, S1, S2, S3, S4});
        @(negedge clock);
        chk("1234_pronto_1cyc", {63'd0, pronto}, 64'd0);
        chk("1234_seg_hold", {8'd0, segmentos}, {8'd0, BL, BL, BL, BL, S1, S2, S3, S4});

        conv(32'd0, lat, ocu0);
        chk("zero_latency", 64'(lat), 64'd33);
        chk("zero_bcd", {32'd0, bcd_digitos}, 64'd0);
        chk("zero_seg", {8'd0, segmentos}, {8'd0, BL, BL, BL, BL, BL, BL, BL, S0});
        @(negedge clock);

        conv(32'd99999999, lat, ocu0);
        chk("max8_bcd", {32'd0, bcd_digitos}, 64'h9999_9999);
        chk("max8_ovf", {63'd0, overflow}, 64'd0);
        chk("max8_seg", {8'd0, segmentos}, {8'd0, {8{S9}}});
        @(negedge clock);

        conv(32'd100000000, lat, ocu0);
        chk("ovf1_ovf", {63'd0, overflow}, 64'd1);
        chk("ovf1_seg", {8'd0, segmentos}, {8'd0, {8{DS}}});
        chk("ovf1_bcd", {32'd0, bcd_digitos}, 64'd0);
        @(negedge clock);

        conv(32'hFFFF_FFFF, lat, ocu0);
        chk("ovf2_ovf", {63'd0, overflow}, 64'd1);
        chk("ovf2_seg", {8'd0, segmentos}, {8'd0, {8{DS}}});
        chk("ovf2_bcd", {32'd0, bcd_digitos}, 64'h9496_7295);
        @(negedge clock);

        // Back-to-back: 5, then 7 and 42 while busy; 42 replaces 7.
        p_cnt = 0; p1 = -1; p2 = -1; ocup1 = 0; ocup_after = 1'b1;
        b1 = '0; b2 = '0; s2 = '0;
        for (int k = 0; k < 70; k++) begin
            out        = (k == 0) || (k == 10) || (k == 20);
            dado_saida = (k == 0) ? 32'd5 : (k == 10) ? 32'd7 : (k == 20) ? 32'd42 : 32'd0;
            @(negedge clock);
            if (k <= 65 && ocupado) ocup1++;
            if (k == 66) ocup_after = ocupado;
            if (pronto) begin
                p_cnt++;
                if (p_cnt == 1) begin
                    p1 = k; b1 = bcd_digitos;
                end else begin
                    p2 = k; b2 = bcd_digitos; s2 = segmentos;
                end
            end
        end
        out = 1'b0;
        chk("b2b_pronto_count", 64'(p_cnt), 64'd2);
        chk("b2b_first_at", 64'(p1), 64'd33);
        chk("b2b_first_bcd", {32'd0, b1}, 64'h5);
        chk("b2b_second_at", 64'(p2), 64'd66);
        chk("b2b_second_bcd", {32'd0, b2}, 64'h42);
        chk("b2b_second_seg", {8'd0, s2}, {8'd0, BL, BL, BL, BL, BL, BL, S4, S2});
        chk("b2b_ocupado_cycles", 64'(ocup1), 64'd66);
        chk("b2b_ocupado_end", {63'd0, ocup_after}, 64'd0);

        // out in the ATUALIZA cycle with value 3.
        p_cnt = 0; p1 = -1; p2 = -1; ocup1 = 0; b1 = '0; b2 = '0;
        for (int k = 0; k < 70; k++) begin
            out        = (k == 0) || (k == 33);
            dado_saida = (k == 0) ? 32'd9 : (k == 33) ? 32'd3 : 32'd0;
            @(negedge clock);
            if (k <= 65 && ocupado) ocup1++;
            if (pronto) begin
                p_cnt++;
                if (p_cnt == 1) begin
                    p1 = k; b1 = bcd_digitos;
                end else begin
                    p2 = k; b2 = bcd_digitos;
                end
            end
        end
        out = 1'b0;
        chk("atu_first_bcd", {32'd0, b1}, 64'h9);
        chk("atu_second_at", 64'(p2), 64'd66);
        chk("atu_second_bcd", {32'd0, b2}, 64'h3);
        chk("atu_seg", {8'd0, segmentos}, {8'd0, BL, BL, BL, BL, BL, BL, BL, S3});
        chk("atu_ocupado_cycles", 64'(ocup1), 64'd66);

        // Reset mid-conversion of 777 with a pending value queued.
        for (int k = 0; k < 15; k++) begin
            out        = (k == 0) || (k == 5);
            dado_saida = (k == 0) ? 32'd777 : (k == 5) ? 32'd11 : 32'd0;
            @(negedge clock);
        end
        out     = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_ocupado", {63'd0, ocupado}, 64'd0);
        chk("mid_rst_pronto", {63'd0, pronto}, 64'd0);
        chk("mid_rst_bcd", {32'd0, bcd_digitos}, 64'd0);
        chk("mid_rst_seg", {8'd0, segmentos}, {8'd0, {8{BL}}});
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        npr = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (pronto) npr++;
        end
        chk("mid_rst_no_pronto", 64'(npr), 64'd0);
        chk("mid_rst_idle", {63'd0, ocupado}, 64'd0);

        conv(32'd8, lat, ocu0);
        chk("after_rst_latency", 64'(lat), 64'd33);
        chk("after_rst_bcd", {32'd0, bcd_digitos}, 64'h8);
        chk("after_rst_seg", {8'd0, segmentos}, {8'd0, BL, BL, BL, BL, BL, BL, BL, S8});
        @(negedge clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
